// File: rtl/digiclk_oci_trace_pkg.sv
// digiclk_oci_trace_pkg: shared state encoding, timestamp width and entry sizing for the OCI trace capture.
package digiclk_oci_trace_pkg;
  typedef enum logic [1:0] {CAPTURE, DRAIN, ENDED} trace_state_e;
  localparam int TS_W = 16;
  function automatic int entry_w(input int dct_w, input int cnt_w, input bit ts_en);
    return dct_w + cnt_w + (ts_en ? TS_W : 0);
  endfunction
endpackage

// File: rtl/digiclk_oci_trace_fifo.sv
// digiclk_oci_trace_fifo: synchronous show-ahead FIFO; a push into a full FIFO succeeds only alongside a pop.
module digiclk_oci_trace_fifo #(
  parameter int WIDTH = 34,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wr_data,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);
  logic [AW:0] wr_q, wr_d, rd_q, rd_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic do_push, do_pop;
  always_comb begin
    empty = wr_q == rd_q;
    full = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    do_pop = pop && !empty;
    do_push = push && (!full || do_pop);
    level = wr_q - rd_q;
    rd_data = empty ? '0 : mem_q[rd_q[AW-1:0]];
    mem_d = mem_q;
    if (do_push) mem_d[wr_q[AW-1:0]] = wr_data;
    wr_d = wr_q + (AW+1)'(do_push);
    rd_d = rd_q + (AW+1)'(do_pop);
  end
  // storage is not reset: cleared pointers make stale contents unreachable
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
    if (!reset_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end
endmodule

// File: rtl/digiclk_cpu_oci_trace_capture.sv
// digiclk_cpu_oci_trace_capture: captures debug-core trace frames into a FIFO, drains on test end.
// Define DCT_TIMESTAMP_EN to store a 16-bit cycle stamp per entry and expose it on rd_ts.
module digiclk_cpu_oci_trace_capture
  import digiclk_oci_trace_pkg::*;
#(
  parameter int DCT_W  = 30,
  parameter int CNT_W  = 4,
  parameter int DEPTH  = 16,
  parameter int DROP_W = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [DCT_W-1:0]         dct_buffer,
  input  logic [CNT_W-1:0]         dct_count,
  input  logic                     dct_valid,
  input  logic                     test_ending,
  input  logic                     rd_ready,
  output logic [DCT_W+CNT_W-1:0]   rd_data,
  output logic                     rd_valid,
  output logic [$clog2(DEPTH):0]   fill_level,
  output logic                     overflow,
  output logic [DROP_W-1:0]        drop_count,
`ifdef DCT_TIMESTAMP_EN
  output logic [TS_W-1:0]          rd_ts,
`endif
  output logic                     test_has_ended,
  output logic                     capturing
);
`ifdef DCT_TIMESTAMP_EN
  localparam bit TS_EN = 1'b1;
`else
  localparam bit TS_EN = 1'b0;
`endif
  localparam int EW = entry_w(DCT_W, CNT_W, TS_EN);
  trace_state_e state_q, state_d;
  logic [DROP_W-1:0] drop_q, drop_d;
  logic ovf_q, ovf_d, want, pop_fire, drop, full, empty;
  logic [EW-1:0] wr_entry, rd_entry;
`ifdef DCT_TIMESTAMP_EN
  logic [TS_W-1:0] ts_q, ts_d;
  assign ts_d = ts_q + 1'b1;
  assign wr_entry = {ts_q, dct_count, dct_buffer};
  assign rd_ts = rd_entry[EW-1 -: TS_W];
  always_ff @(posedge clk) ts_q <= !reset_n ? '0 : ts_d;
`else
  assign wr_entry = {dct_count, dct_buffer};
`endif
  assign rd_data = rd_entry[DCT_W+CNT_W-1:0];
  digiclk_oci_trace_fifo #(.WIDTH(EW), .DEPTH(DEPTH)) u_fifo (
    .clk(clk), .reset_n(reset_n), .push(want), .pop(rd_ready), .wr_data(wr_entry),
    .rd_data(rd_entry), .full(full), .empty(empty), .level(fill_level)
  );
  // the push decision uses the pre-edge state, so a frame beside test_ending is kept
  always_comb begin
    capturing = state_q == CAPTURE;
    test_has_ended = state_q == ENDED;
    rd_valid = !empty;
    overflow = ovf_q;
    drop_count = drop_q;
    want = capturing && dct_valid && (dct_count != '0);
    pop_fire = rd_valid && rd_ready;
    drop = want && full && !pop_fire;
    drop_d = drop_q + DROP_W'(drop && !(&drop_q));
    ovf_d = ovf_q | drop;
    state_d = (state_q == CAPTURE && test_ending) ? DRAIN :
              (state_q == DRAIN && fill_level == '0) ? ENDED : state_q;
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= CAPTURE;
      drop_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      drop_q <= drop_d;
      ovf_q <= ovf_d;
    end
  end
endmodule
